// File: rtl/cr_controller_receiver.sv
// Cognitive-radio receiver: sorts band words by tag into licensed outputs or the unlicensed FIFO.
// Latency: licensed words and FIFO pushes appear one edge after sampling; u_out is first-word-fall-through.
// Backpressure: u_ready stalls FIFO drain; pushes beyond free space (sampled pre-edge) are dropped.
//
// Ports: clk/rst (async active-high); band_valid[2:0] + band1..3_data (tag in MSB);
//        l_out1..3 / l_valid per-band licensed outputs; u_out/u_valid/u_ready unlicensed drain;
//        band_state (2 bits per band, band1 in [1:0]); fifo_level occupancy;
//        drop_cnt saturating drop counter, present only when CR_RX_DROPCNT_EN is defined.
module cr_controller_receiver #(
    parameter int D_LEN      = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int HOLD       = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [2:0]                    band_valid,
    input  logic [2*D_LEN:0]              band1_data,
    input  logic [2*D_LEN:0]              band2_data,
    input  logic [2*D_LEN:0]              band3_data,
    output logic [D_LEN-1:0]              l_out1,
    output logic [D_LEN-1:0]              l_out2,
    output logic [D_LEN-1:0]              l_out3,
    output logic [2:0]                    l_valid,
    output logic [D_LEN-1:0]              u_out,
    output logic                          u_valid,
    input  logic                          u_ready,
    output logic [5:0]                    band_state,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef CR_RX_DROPCNT_EN
    ,
    output logic [7:0]                    drop_cnt
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int WW = 2 * D_LEN + 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_LICENSED = 2'b01,
        ST_SHARED   = 2'b10
    } state_t;

    logic [WW-1:0]    bdata [3];
    logic [D_LEN-1:0] l_q   [3];

    assign bdata[0] = band1_data;
    assign bdata[1] = band2_data;
    assign bdata[2] = band3_data;

    assign l_out1 = l_q[0];
    assign l_out2 = l_q[1];
    assign l_out3 = l_q[2];

    // ------------------------------------------------------------------
    // Unlicensed push candidates, in fixed push order b1L,b1H,b2L,b2H,b3L,b3H
    // ------------------------------------------------------------------
    logic [D_LEN-1:0] cand_dat [6];
    logic [5:0]       cand_vld;

    always_comb begin
        for (int b = 0; b < 3; b++) begin
            cand_vld[2*b]     = band_valid[b] & bdata[b][2*D_LEN];
            cand_vld[2*b+1]   = band_valid[b] & bdata[b][2*D_LEN];
            cand_dat[2*b]     = bdata[b][D_LEN-1:0];
            cand_dat[2*b+1]   = bdata[b][2*D_LEN-1:D_LEN];
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [D_LEN-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    free_space;
    logic [LW-1:0]    acc_cnt;
    logic [5:0]       acc;
    logic [PW-1:0]    off [6];
    logic             pop;
`ifdef CR_RX_DROPCNT_EN
    logic [2:0]       drop_num;
    logic [7:0]       drop_q;
    logic [8:0]       drop_sum;
`endif

    assign u_valid    = (fifo_level != '0);
    assign pop        = u_valid & u_ready;
    assign u_out      = u_valid ? mem[rd_ptr] : '0;
    // Room is judged on the pre-edge level only; a same-cycle pop frees nothing.
    assign free_space = LW'(FIFO_DEPTH) - fifo_level;

    // Each accepted word gets a slot offset from wr_ptr equal to the number
    // of words accepted ahead of it this cycle.
    always_comb begin
        acc_cnt = '0;
        acc     = '0;
`ifdef CR_RX_DROPCNT_EN
        drop_num = '0;
`endif
        for (int i = 0; i < 6; i++) begin
            off[i] = '0;
            if (cand_vld[i]) begin
                if (acc_cnt < free_space) begin
                    acc[i]  = 1'b1;
                    off[i]  = acc_cnt[PW-1:0];
                    acc_cnt = acc_cnt + LW'(1);
                end
`ifdef CR_RX_DROPCNT_EN
                else begin
                    drop_num = drop_num + 3'd1;
                end
`endif
            end
        end
    end

    // Storage is not reset: pointers and level define what is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 6; i++) begin
            if (acc[i]) begin
                mem[wr_ptr + off[i]] <= cand_dat[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            wr_ptr     <= wr_ptr + acc_cnt[PW-1:0];
            rd_ptr     <= rd_ptr + PW'(pop);
            fifo_level <= fifo_level + acc_cnt - LW'(pop);
        end
    end

`ifdef CR_RX_DROPCNT_EN
    assign drop_sum = {1'b0, drop_q} + 9'(drop_num);
    assign drop_cnt = drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
        end
    end
`endif

    // ------------------------------------------------------------------
    // Licensed per-band outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 3; b++) begin
                l_q[b] <= '0;
            end
            l_valid <= '0;
        end else begin
            for (int b = 0; b < 3; b++) begin
                if (band_valid[b] && !bdata[b][2*D_LEN]) begin
                    l_q[b]     <= bdata[b][D_LEN-1:0];
                    l_valid[b] <= 1'b1;
                end else begin
                    l_valid[b] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-band occupancy state machine
    // ------------------------------------------------------------------
    state_t     state_q [3];
    state_t     state_d [3];
    logic [7:0] idle_q  [3];
    logic [7:0] idle_d  [3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 3; b++) begin
                state_q[b] <= ST_IDLE;
                idle_q[b]  <= '0;
            end
        end else begin
            for (int b = 0; b < 3; b++) begin
                state_q[b] <= state_d[b];
                idle_q[b]  <= idle_d[b];
            end
        end
    end

    always_comb begin
        for (int b = 0; b < 3; b++) begin
            state_d[b] = state_q[b];
            idle_d[b]  = idle_q[b];
            if (band_valid[b]) begin
                state_d[b] = bdata[b][2*D_LEN] ? ST_SHARED : ST_LICENSED;
                idle_d[b]  = '0;
            end else begin
                case (state_q[b])
                    ST_LICENSED, ST_SHARED: begin
                        // Drop to IDLE on the HOLD-th consecutive idle edge.
                        if (idle_q[b] + 8'd1 == 8'(HOLD)) begin
                            state_d[b] = ST_IDLE;
                            idle_d[b]  = '0;
                        end else begin
                            idle_d[b]  = idle_q[b] + 8'd1;
                        end
                    end
                    default: begin
                        state_d[b] = ST_IDLE;
                        idle_d[b]  = '0;
                    end
                endcase
            end
        end
    end

    assign band_state = {state_q[2], state_q[1], state_q[0]};

endmodule

// File: tb/tb_cr_controller_receiver.sv
// Directed bench for cr_controller_receiver (D_LEN=32, FIFO_DEPTH=8, HOLD=4).
// Inputs change 1 time unit after the rising edge; outputs are checked at that same point.
// drop_cnt is checked only when CR_RX_DROPCNT_EN is defined.
module tb_cr_controller_receiver;

    logic        clk;
    logic        rst;
    logic [2:0]  band_valid;
    logic [64:0] band1_data;
    logic [64:0] band2_data;
    logic [64:0] band3_data;
    logic [31:0] l_out1;
    logic [31:0] l_out2;
    logic [31:0] l_out3;
    logic [2:0]  l_valid;
    logic [31:0] u_out;
    logic        u_valid;
    logic        u_ready;
    logic [5:0]  band_state;
    logic [3:0]  fifo_level;
`ifdef CR_RX_DROPCNT_EN
    logic [7:0]  drop_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    cr_controller_receiver #(
        .D_LEN      (32),
        .FIFO_DEPTH (8),
        .HOLD       (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .band_valid (band_valid),
        .band1_data (band1_data),
        .band2_data (band2_data),
        .band3_data (band3_data),
        .l_out1     (l_out1),
        .l_out2     (l_out2),
        .l_out3     (l_out3),
        .l_valid    (l_valid),
        .u_out      (u_out),
        .u_valid    (u_valid),
        .u_ready    (u_ready),
        .band_state (band_state),
        .fifo_level (fifo_level)
`ifdef CR_RX_DROPCNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] drain_exp [8];

    initial begin
        rst        = 1'b1;
        band_valid = '0;
        band1_data = '0;
        band2_data = '0;
        band3_data = '0;
        u_ready    = 1'b0;
        #3;
        // Reset state
        chk("rst_l_out1",   64'(l_out1),     64'h0);
        chk("rst_l_out2",   64'(l_out2),     64'h0);
        chk("rst_l_out3",   64'(l_out3),     64'h0);
        chk("rst_l_valid",  64'(l_valid),    64'h0);
        chk("rst_u_out",    64'(u_out),      64'h0);
        chk("rst_u_valid",  64'(u_valid),    64'h0);
        chk("rst_state",    64'(band_state), 64'h0);
        chk("rst_level",    64'(fifo_level), 64'h0);
`ifdef CR_RX_DROPCNT_EN
        chk("rst_drop",     64'(drop_cnt),   64'h0);
`endif
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_l_valid", 64'(l_valid), 64'h0);

        // Licensed words on bands 1 and 3; high halves must be ignored
        band_valid = 3'b101;
        band1_data = {1'b0, 32'h1234_5678, 32'hDEAD_BEEF};
        band3_data = {1'b0, 32'hFFFF_FFFF, 32'h0000_CAFE};
        tick();
        chk("lic_l_out1",  64'(l_out1),     64'hDEAD_BEEF);
        chk("lic_l_out3",  64'(l_out3),     64'h0000_CAFE);
        chk("lic_l_out2",  64'(l_out2),     64'h0);
        chk("lic_l_valid", 64'(l_valid),    64'h5);
        chk("lic_state",   64'(band_state), 64'b01_00_01);
        chk("lic_level",   64'(fifo_level), 64'h0);
        band_valid = 3'b000;
        tick();
        chk("lic_pulse_end", 64'(l_valid), 64'h0);
        chk("lic_hold",      64'(l_out1),  64'hDEAD_BEEF);

        // Shared word on band2, drained immediately
        band_valid = 3'b010;
        band2_data = {1'b1, 32'h0000_0002, 32'h0000_0001};
        u_ready    = 1'b1;
        tick();
        chk("sh_level2", 64'(fifo_level), 64'h2);
        chk("sh_u_out1", 64'(u_out),      64'h1);
        chk("sh_valid",  64'(u_valid),    64'h1);
        chk("sh_lvalid", 64'(l_valid),    64'h0);
        band_valid = 3'b000;
        tick();
        chk("sh_level1", 64'(fifo_level), 64'h1);
        chk("sh_u_out2", 64'(u_out),      64'h2);
        tick();
        chk("sh_level0", 64'(fifo_level), 64'h0);
        chk("sh_empty",  64'(u_valid),    64'h0);
        chk("sh_u_out0", 64'(u_out),      64'h0);
        // Bands 1 and 3 have now seen 4 idle edges; band2 has seen 2
        chk("sh_state",  64'(band_state), 64'b00_10_00);

        // Overflow: 12 words offered with u_ready low, only 8 fit
        u_ready    = 1'b0;
        band_valid = 3'b111;
        band1_data = {1'b1, 32'hA1, 32'hA0};
        band2_data = {1'b1, 32'hB1, 32'hB0};
        band3_data = {1'b1, 32'hC1, 32'hC0};
        tick();
        chk("ovf_level6", 64'(fifo_level), 64'h6);
        band1_data = {1'b1, 32'hA3, 32'hA2};
        band2_data = {1'b1, 32'hB3, 32'hB2};
        band3_data = {1'b1, 32'hC3, 32'hC2};
        tick();
        chk("ovf_level8", 64'(fifo_level), 64'h8);
        chk("ovf_head",   64'(u_out),      64'hA0);
        chk("ovf_state",  64'(band_state), 64'b10_10_10);
`ifdef CR_RX_DROPCNT_EN
        chk("ovf_drop",   64'(drop_cnt),   64'h4);
`endif
        drain_exp = '{32'hA0, 32'hA1, 32'hB0, 32'hB1, 32'hC0, 32'hC1, 32'hA2, 32'hA3};
        band_valid = 3'b000;
        u_ready    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_%0d", i), 64'(u_out), 64'(drain_exp[i]));
            tick();
        end
        chk("drain_level", 64'(fifo_level), 64'h0);
        chk("drain_empty", 64'(u_valid),    64'h0);

        // HOLD timing on band1
        band_valid = 3'b001;
        band1_data = {1'b1, 32'h55, 32'h44};
        tick();
        chk("hold_shared", 64'(band_state), 64'b00_00_10);
        chk("hold_u_out",  64'(u_out),      64'h44);
        band_valid = 3'b000;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("hold_idle%0d", i), 64'(band_state[1:0]), 64'b10);
        end
        tick();
        chk("hold_to_idle", 64'(band_state[1:0]), 64'b00);

        // Mid-operation reset with 5 words in the FIFO
        u_ready    = 1'b0;
        band_valid = 3'b111;
        tick();
        band_valid = 3'b000;
        u_ready    = 1'b1;
        tick();
        chk("mid_level5", 64'(fifo_level), 64'h5);
        rst = 1'b1;
        #1;
        chk("mid_rst_level", 64'(fifo_level), 64'h0);
        chk("mid_rst_valid", 64'(u_valid),    64'h0);
        chk("mid_rst_u_out", 64'(u_out),      64'h0);
        chk("mid_rst_state", 64'(band_state), 64'h0);
        tick();
        chk("mid_rst_hold_level", 64'(fifo_level), 64'h0);
        chk("mid_rst_hold_valid", 64'(u_valid),    64'h0);
        rst = 1'b0;
        tick();
        chk("post_mid_l_valid", 64'(l_valid),    64'h0);
        chk("post_mid_u_valid", 64'(u_valid),    64'h0);
        chk("post_mid_level",   64'(fifo_level), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
